// File: rtl/fft_pkg.sv
// Shared types and butterfly address math for the radix-2 DIT FFT stage controller.
package fft_pkg;

  localparam int unsigned LOG2N_MAX = 12;
  localparam int unsigned STG_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RDW,
    ST_BUTT,
    ST_WRA,
    ST_WRB,
    ST_STG,
    ST_FIN
  } fft_ctrl_state_e;

  typedef struct packed {
    logic [LOG2N_MAX-1:0] addr_a;
    logic [LOG2N_MAX-1:0] addr_b;
    logic [LOG2N_MAX-2:0] tw_idx;
  } bfly_addr_t;

  // Pair and twiddle for butterfly b of stage s, computed at the maximum supported size.
  function automatic bfly_addr_t bfly_addr(input logic [STG_W-1:0]     s,
                                           input logic [LOG2N_MAX-2:0] b,
                                           input logic [STG_W-1:0]     log2n);
    logic [LOG2N_MAX-1:0] span;
    logic [LOG2N_MAX-1:0] pos;
    logic [LOG2N_MAX-1:0] grp;
    logic [LOG2N_MAX-1:0] a;
    bfly_addr_t           r;
    span = LOG2N_MAX'(1) << s;
    pos  = {1'b0, b} & (span - LOG2N_MAX'(1));
    grp  = {1'b0, b} >> s;
    a    = (grp << (s + STG_W'(1))) | pos;
    r.addr_a = a;
    r.addr_b = a + span;
    r.tw_idx = (LOG2N_MAX-1)'(pos << (log2n - STG_W'(1) - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Registered butterfly address / twiddle generator; loads a new (stage, butterfly) on ld.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               ld,
  input  logic [STG_W-1:0]   stage,
  input  logic [LOG2N-2:0]   bfly,
  output logic [LOG2N-1:0]   addr_a,
  output logic [LOG2N-1:0]   addr_b,
  output logic [LOG2N-2:0]   tw_idx
);

  bfly_addr_t nxt;
  logic       unused_addr_bits;

  assign nxt = bfly_addr(stage, (LOG2N_MAX-1)'(bfly), STG_W'(LOG2N));
  // Upper bits are zero for LOG2N below the maximum.
  assign unused_addr_bits = ^nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a <= '0;
      addr_b <= '0;
      tw_idx <= '0;
    end else if (clr) begin
      addr_a <= '0;
      addr_b <= '0;
      tw_idx <= '0;
    end else if (ld) begin
      addr_a <= LOG2N'(nxt.addr_a);
      addr_b <= LOG2N'(nxt.addr_b);
      tw_idx <= (LOG2N-1)'(nxt.tw_idx);
    end
  end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Control FSM for the in-place radix-2 DIT FFT: stage/butterfly sequencing, bank ping-pong, handshakes.
// Optional IFFT support (i_inverse, o_tw_conj, o_scale) when FFT_STAGE_CTRL_INVERSE_EN is defined.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N  = 11,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_abort,
  input  logic             i_bfly_done,
`ifdef FFT_STAGE_CTRL_INVERSE_EN
  input  logic             i_inverse,
  output logic             o_tw_conj,
  output logic             o_scale,
`endif
  output logic             o_rd_en,
  output logic             o_rd_bank,
  output logic [LOG2N-1:0] o_addr_a,
  output logic [LOG2N-1:0] o_addr_b,
  output logic [LOG2N-2:0] o_tw_idx,
  output logic             o_bfly_en,
  output logic             o_wr_en,
  output logic             o_wr_sel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_result_bank
);

  localparam int unsigned BW    = LOG2N - 1;
  localparam int unsigned LAT_W = 3;
  localparam logic [STG_W-1:0] LAST_STG  = STG_W'(LOG2N - 1);
  localparam logic [BW-1:0]    LAST_BFLY = '1;
  localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'(RD_LAT - 1);

  fft_ctrl_state_e   state;
  logic [STG_W-1:0]  stage;
  logic [BW-1:0]     bfly;
  logic [LAT_W-1:0]  lat_cnt;

  logic              enter_rd_c;
  logic              clr_c;
  logic [STG_W-1:0]  ld_stage_c;
  logic [BW-1:0]     ld_bfly_c;

  // Next butterfly coordinates, shared by the counters and the address generator.
  always_comb begin
    enter_rd_c = 1'b0;
    clr_c      = 1'b0;
    ld_stage_c = stage;
    ld_bfly_c  = '0;
    if (state != ST_IDLE && i_abort) begin
      clr_c = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (i_en) begin
          enter_rd_c = 1'b1;
          ld_stage_c = '0;
        end
        ST_WRB: if (bfly != LAST_BFLY) begin
          enter_rd_c = 1'b1;
          ld_bfly_c  = bfly + BW'(1);
        end
        ST_STG: if (stage != LAST_STG) begin
          enter_rd_c = 1'b1;
          ld_stage_c = stage + STG_W'(1);
        end
        default: ;
      endcase
    end
  end

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clr    (clr_c),
    .ld     (enter_rd_c),
    .stage  (ld_stage_c),
    .bfly   (ld_bfly_c),
    .addr_a (o_addr_a),
    .addr_b (o_addr_b),
    .tw_idx (o_tw_idx)
  );

  // Strobes default low each cycle and are raised on entry to the state that owns them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      stage         <= '0;
      bfly          <= '0;
      lat_cnt       <= '0;
      o_rd_en       <= 1'b0;
      o_rd_bank     <= 1'b0;
      o_bfly_en     <= 1'b0;
      o_wr_en       <= 1'b0;
      o_wr_sel      <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_result_bank <= 1'b0;
    end else begin
      o_rd_en   <= 1'b0;
      o_bfly_en <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_sel  <= 1'b0;
      o_done    <= 1'b0;
      if (clr_c) begin
        state     <= ST_IDLE;
        stage     <= '0;
        bfly      <= '0;
        lat_cnt   <= '0;
        o_rd_bank <= 1'b0;
        o_busy    <= 1'b0;
      end else begin
        if (enter_rd_c) begin
          state   <= ST_RD;
          stage   <= ld_stage_c;
          bfly    <= ld_bfly_c;
          o_rd_en <= 1'b1;
          o_busy  <= 1'b1;
        end
        case (state)
          ST_IDLE: if (i_en) o_rd_bank <= 1'b0;
          ST_RD: begin
            state   <= ST_RDW;
            lat_cnt <= '0;
          end
          ST_RDW: begin
            if (lat_cnt == LAST_LAT) begin
              state     <= ST_BUTT;
              o_bfly_en <= 1'b1;
            end else begin
              lat_cnt <= lat_cnt + LAT_W'(1);
            end
          end
          ST_BUTT: begin
            if (i_bfly_done) begin
              state   <= ST_WRA;
              o_wr_en <= 1'b1;
            end else begin
              o_bfly_en <= 1'b1;
            end
          end
          ST_WRA: begin
            state    <= ST_WRB;
            o_wr_en  <= 1'b1;
            o_wr_sel <= 1'b1;
          end
          ST_WRB: if (!enter_rd_c) state <= ST_STG;
          ST_STG: begin
            o_rd_bank <= ~o_rd_bank;
            bfly      <= '0;
            if (!enter_rd_c) begin
              state         <= ST_FIN;
              o_done        <= 1'b1;
              o_result_bank <= 1'(LOG2N % 2);
            end
          end
          ST_FIN: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef FFT_STAGE_CTRL_INVERSE_EN
  // Direction is captured at start; scaling is requested on both write cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tw_conj <= 1'b0;
      o_scale   <= 1'b0;
    end else begin
      if (state == ST_IDLE && i_en) o_tw_conj <= i_inverse;
      o_scale <= !clr_c && ((state == ST_BUTT && i_bfly_done) || state == ST_WRA);
    end
  end
`else
  // Forward-only build: no conjugation or per-stage scaling outputs.
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Scoreboard bench for fft_stage_ctrl (LOG2N=3, RD_LAT=1); define FFT_STAGE_CTRL_INVERSE_EN to cover the IFFT ports.
module tb_fft_stage_ctrl;

  localparam int unsigned LOG2N  = 3;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned N      = 1 << LOG2N;
  localparam int unsigned NB     = LOG2N * (N / 2);
  localparam int unsigned LAT    = NB * (4 + RD_LAT) + LOG2N + 1;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned tw;
    int unsigned bank;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             abort = 1'b0;
  logic             bfly_done = 1'b0;
  logic             rd_en, rd_bank, bfly_en, wr_en, wr_sel, busy, done, result_bank;
  logic [LOG2N-1:0] addr_a, addr_b;
  logic [LOG2N-2:0] tw_idx;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
  logic             inverse = 1'b0;
  logic             tw_conj, scale;
`endif

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   rd_cnt = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   bfly_delay = 1;
  int   butt_cnt = 0;
  bit   wr_phase = 1'b0;
  bit   inv_exp = 1'b0;

  fft_stage_ctrl #(.LOG2N(LOG2N), .RD_LAT(RD_LAT)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_abort       (abort),
    .i_bfly_done   (bfly_done),
`ifdef FFT_STAGE_CTRL_INVERSE_EN
    .i_inverse     (inverse),
    .o_tw_conj     (tw_conj),
    .o_scale       (scale),
`endif
    .o_rd_en       (rd_en),
    .o_rd_bank     (rd_bank),
    .o_addr_a      (addr_a),
    .o_addr_b      (addr_b),
    .o_tw_idx      (tw_idx),
    .o_bfly_en     (bfly_en),
    .o_wr_en       (wr_en),
    .o_wr_sel      (wr_sel),
    .o_busy        (busy),
    .o_done        (done),
    .o_result_bank (result_bank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Butterfly datapath model: result valid bfly_delay cycles into BUTT.
  always @(negedge clk) begin
    if (bfly_en) begin
      butt_cnt++;
      bfly_done = (butt_cnt >= bfly_delay);
    end else begin
      butt_cnt  = 0;
      bfly_done = 1'b0;
    end
  end

  // Output monitor: pops one expected butterfly per read strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        rd_cnt++;
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          cur = sb.pop_front();
          check_eq("rd_addr_a", 32'(addr_a), cur.a);
          check_eq("rd_addr_b", 32'(addr_b), cur.b);
          check_eq("rd_tw_idx", 32'(tw_idx), cur.tw);
          check_eq("rd_bank", 32'(rd_bank), cur.bank);
          wr_phase = 1'b0;
        end
      end
      if (wr_en) begin
        check_eq("wr_addr_a", 32'(addr_a), cur.a);
        check_eq("wr_addr_b", 32'(addr_b), cur.b);
        check_eq("wr_sel", 32'(wr_sel), 32'(wr_phase));
        wr_phase = 1'b1;
      end
      if (done) done_cnt++;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
      if (busy) check_eq("tw_conj", 32'(tw_conj), 32'(inv_exp));
      check_eq("scale", 32'(scale), 32'(wr_en));
`endif
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq(tag, 32'({rd_en, rd_bank, addr_a, addr_b, tw_idx, bfly_en, wr_en, wr_sel,
                       done, result_bank}), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef FFT_STAGE_CTRL_INVERSE_EN
    check_eq({tag, "_inv"}, 32'({tw_conj, scale}), 32'd0);
`endif
  endtask

  task automatic start_run(input bit inv);
    exp_t e;
    sb.delete();
    for (int s = 0; s < int'(LOG2N); s++) begin
      for (int g = 0; g < int'(N) / (2 << s); g++) begin
        for (int p = 0; p < (1 << s); p++) begin
          e.a    = int'(g * (2 << s) + p);
          e.b    = e.a + (1 << s);
          e.tw   = int'(p * (int'(N) / (2 << s)));
          e.bank = s % 2;
          sb.push_back(e);
        end
      end
    end
    inv_exp = inv;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
    inverse = inv;
`endif
    @(negedge clk);
    en      = 1'b1;
    t_start = cyc;
    rd_cnt  = 0;
    @(negedge clk);
    en = 1'b0;
`ifdef FFT_STAGE_CTRL_INVERSE_EN
    inverse = ~inv;
`endif
  endtask

  task automatic wait_done(input int exp_lat);
    int guard = 0;
    while (!done && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("latency", 32'(cyc - t_start), 32'(exp_lat));
    check_eq("result_bank", 32'(result_bank), 32'(LOG2N % 2));
  endtask

  initial begin
    int dc;
    int guard;

    // Reset with random inputs.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en    = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
`ifdef FFT_STAGE_CTRL_INVERSE_EN
      inverse = 1'($urandom_range(0, 1));
`endif
      #1 check_all_zero("reset_out");
    end
    @(negedge clk);
    en    = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle_out");

    // Full transform, datapath answers one cycle into BUTT.
    dc = done_cnt;
    start_run(1'b1);
    wait_done(LAT);
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("sb_empty_1", 32'(sb.size()), 32'd0);
    check_eq("done_cnt_1", 32'(done_cnt - dc), 32'd1);

    // Stall: result held off for 10 extra cycles on the first butterfly.
    bfly_delay = 11;
    start_run(1'b0);
    guard = 0;
    while (!bfly_en && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("stall_enter", 32'(bfly_en), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_bfly_en", 32'(bfly_en), 32'd1);
      check_eq("stall_addr", 32'({addr_a, addr_b}), 32'({3'd0, 3'd1}));
      check_eq("stall_wr_en", 32'(wr_en), 32'd0);
    end
    bfly_delay = 1;
    wait_done(LAT + 10);
    check_eq("sb_empty_2", 32'(sb.size()), 32'd0);

    // Abort in stage 1, coinciding with butterfly done; then restart.
    start_run(1'b0);
    guard = 0;
    while (!(bfly_en && rd_bank) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check_eq("abort_reach_stg1", 32'(bfly_en && rd_bank), 32'd1);
    dc    = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_wr_en", 32'(wr_en), 32'd0);
    check_eq("abort_bfly_en", 32'(bfly_en), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("abort_no_done", 32'(done_cnt - dc), 32'd0);
    check_eq("abort_res_bank", 32'(result_bank), 32'd1);
    start_run(1'b1);
    wait_done(LAT);
    check_eq("sb_empty_3", 32'(sb.size()), 32'd0);

    // Asynchronous reset in stage 2, then a run with i_en pulses while busy and in FIN.
    start_run(1'b0);
    guard = 0;
    while (rd_cnt < 10 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check_eq("reach_stg2", 32'(rd_cnt >= 10), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dc = done_cnt;
    start_run(1'b0);
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    wait_done(LAT);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check_eq("fin_en_busy", 32'(busy), 32'd0);
    check_eq("fin_en_rd", 32'(rd_en), 32'd0);
    repeat (30) @(negedge clk);
    check_eq("single_done", 32'(done_cnt - dc), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("sb_empty_4", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
